// File: rtl/hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Detects load-use hazards, freezes
//               the whole pipeline while data memory is busy (IDLE/WAIT/DONE
//               FSM), defers a taken-branch flush until the pipeline can move,
//               flags long memory waits and counts stall cycles.
// Revision    : 1.0 - initial release
//==============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic [2:0]  rs_ID,
    input  logic [2:0]  rt_ID,
    input  logic        rsValid_ID,
    input  logic        rtValid_ID,
    input  logic [2:0]  writeregsel_EX,
    input  logic        RegWrite_EX,
    input  logic        memRead_EX,
    input  logic        branchTaken_EX,
    input  logic        memReq,
    input  logic        memStall,
    output logic        isAllStall,
    output logic        isDataStall,
    output logic        dependentLoad,
    output logic        isFlush,
    output logic        memDone,
    output logic        pcWrite_en,
    output logic        memTimeout,
    output logic [15:0] stallCycles
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [7:0] c_WAIT_MAX = 8'hFF;

    logic [1:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_flush_pending;
    logic [15:0] r_stall_cycles;

    logic        w_run;          // high when not held in reset
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_mem_start;
    logic        w_all_stall;
    logic        w_mem_done;
    logic        w_advance;      // pipeline registers may load this cycle
    logic        w_flush;
    logic        w_data_stall;
    logic        w_count_stall;

    assign w_run = rst;

    // Load-use hazard: the EX load writes a register the ID instruction reads.
    assign w_rs_hit      = rsValid_ID && (rs_ID == writeregsel_EX);
    assign w_rt_hit      = rtValid_ID && (rt_ID == writeregsel_EX);
    assign dependentLoad = memRead_EX && RegWrite_EX && (w_rs_hit || w_rt_hit);

    // A new access only starts from IDLE; a request seen in DONE is ignored
    // until the FSM is back in IDLE.
    assign w_mem_start = (r_state == c_ST_IDLE) && memReq && memStall;

    assign w_all_stall = w_run && (w_mem_start ||
                                   (r_state == c_ST_WAIT) ||
                                   (r_state == c_ST_DONE));
    assign w_mem_done  = w_run && (r_state == c_ST_DONE);
    assign w_advance   = !w_all_stall || w_mem_done;

    // The flush waits for the pipeline to move; the squashed ID instruction
    // must not also raise a data stall.
    assign w_flush      = w_run && (branchTaken_EX || r_flush_pending) && w_advance;
    assign w_data_stall = w_run && dependentLoad && !w_flush && !w_all_stall;
    assign w_count_stall = (w_all_stall && !w_mem_done) || w_data_stall;

    assign isAllStall  = w_all_stall;
    assign memDone     = w_mem_done;
    assign isFlush     = w_flush;
    assign isDataStall = w_data_stall;
    assign pcWrite_en  = w_run && !w_data_stall && w_advance;
    assign memTimeout  = w_run && (r_state == c_ST_WAIT) && (r_wait_cnt == c_WAIT_MAX);
    assign stallCycles = r_stall_cycles;

    // Memory access FSM with saturating wait-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (memReq && memStall) begin
                        r_state    <= c_ST_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt != c_WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                    if (!memStall) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Remember a branch taken while the pipeline is frozen until it can flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_pending <= 1'b0;
        end else if (w_flush) begin
            r_flush_pending <= 1'b0;
        end else if (branchTaken_EX && w_all_stall && !w_mem_done) begin
            r_flush_pending <= 1'b1;
        end
    end

    // Free-running (wrapping) stall performance counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= 16'd0;
        end else if (w_count_stall) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

endmodule
`default_nettype wire
